// File: rtl/edge_trig_seq.sv
// Sequencer for the edge-trigger datapath: resets and starts the moving-sum core, waits for the
// window to fill, then gates comparator triggers with holdoff, auto re-arm and timeout.
module edge_trig_seq #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned TO_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                abort,
  input  logic                auto_rearm,
  input  logic [7:0]          trig_target,
  input  logic [7:0]          settle_cnt,
  input  logic [15:0]         holdoff_cnt,
  input  logic [TO_WIDTH-1:0] timeout_cnt,
  input  logic                sum_valid,
  input  logic                raw_trig,
  output logic                core_rst,
  output logic                core_start,
  output logic                trig_out,
  output logic                busy,
  output logic                done,
  output logic                timed_out,
  output logic [7:0]          trig_count
);

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCoreRst,
    StSettle,
    StArmed,
    StHoldoff,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
  logic [7:0]          settle_q, settle_d;
  logic [TO_WIDTH-1:0] to_q, to_d;
  logic [15:0]         hold_q, hold_d;
  logic                trig_q, trig_d;
  logic [7:0]          trig_count_q, trig_count_d;
  logic                timed_out_q, timed_out_d;

  logic [7:0]          settle_inc;
  logic [TO_WIDTH-1:0] to_inc;
  logic [7:0]          target_eff;

  assign settle_inc = settle_q + 8'd1;
  assign to_inc     = to_q + TO_WIDTH'(1);
  assign target_eff = (trig_target == 8'd0) ? 8'd1 : trig_target;

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    settle_d     = settle_q;
    to_d         = to_q;
    hold_d       = hold_q;
    trig_d       = 1'b0;
    trig_count_d = trig_count_q;
    timed_out_d  = timed_out_q;

    // abort outranks everything; counters and sticky status are deliberately held
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (arm) begin
            state_d      = StCoreRst;
            rst_cnt_d    = '0;
            timed_out_d  = 1'b0;
            trig_count_d = 8'd0;
          end
        end
        StCoreRst: begin
          if (rst_cnt_q == RstLast) begin
            state_d  = StSettle;
            settle_d = 8'd0;
          end else begin
            rst_cnt_d = rst_cnt_q + RstW'(1);
          end
        end
        StSettle: begin
          if (settle_cnt == 8'd0) begin
            state_d = StArmed;
            to_d    = '0;
          end else if (sum_valid) begin
            if (settle_inc == settle_cnt) begin
              state_d = StArmed;
              to_d    = '0;
            end else begin
              settle_d = settle_inc;
            end
          end
        end
        StArmed: begin
          // a trigger in the timeout cycle wins over the timeout
          if (raw_trig) begin
            trig_d  = 1'b1;
            hold_d  = holdoff_cnt;
            state_d = StHoldoff;
            if (trig_count_q != 8'hff) trig_count_d = trig_count_q + 8'd1;
          end else if ((timeout_cnt != '0) && (to_inc == timeout_cnt)) begin
            timed_out_d = 1'b1;
            state_d     = StDone;
          end else begin
            to_d = to_inc;
          end
        end
        StHoldoff: begin
          if (hold_q == 16'd0) begin
            if (auto_rearm && (trig_count_q < target_eff)) begin
              state_d = StArmed;
              to_d    = '0;
            end else begin
              state_d = StDone;
            end
          end else begin
            hold_d = hold_q - 16'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      rst_cnt_q    <= '0;
      settle_q     <= 8'd0;
      to_q         <= '0;
      hold_q       <= 16'd0;
      trig_q       <= 1'b0;
      trig_count_q <= 8'd0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      settle_q     <= settle_d;
      to_q         <= to_d;
      hold_q       <= hold_d;
      trig_q       <= trig_d;
      trig_count_q <= trig_count_d;
      timed_out_q  <= timed_out_d;
    end
  end

  assign core_rst   = (state_q == StCoreRst);
  assign core_start = (state_q == StSettle) || (state_q == StArmed) || (state_q == StHoldoff);
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign done       = (state_q == StDone);
  assign trig_out   = trig_q;
  assign timed_out  = timed_out_q;
  assign trig_count = trig_count_q;

endmodule
